// File: rtl/seq_serializer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared definitions for the serializer feeding the sequence
//            detector: idle line level, FSM state encoding and a clog2 helper
//            that never returns zero (so counters keep at least one bit).
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

  // Level driven on the serial line when no word is being shifted.
  localparam logic IDLE_LEVEL = 1'b0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // $clog2 clamped to a minimum of 1 so a counter for a single value still
  // has a legal width.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_bit_tick.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : seq_bit_tick
// Purpose  : Per-bit timing for the serializer. Counts CLKS_PER_BIT cycles
//            while enabled and strobes bit_done on the last cycle of a bit.
//            The count restarts whenever the shifter is loaded.
// Ports    : clk      - clock
//            rst      - asynchronous active-high reset
//            clr      - shifter load this cycle; restart the count
//            en       - a bit is currently on the line
//            bit_done - final cycle of the current bit
// Revision : 1.0 - initial release
// ============================================================================
module seq_bit_tick
  import seq_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_done
);

  generate
    if (CLKS_PER_BIT == 1) begin : g_single
      // Every enabled cycle is a complete bit; no counter needed.
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst, clr};
      assign bit_done = en;
    end else begin : g_count
      localparam int CW = clog2_min1(CLKS_PER_BIT);
      localparam logic [CW-1:0] c_last = CW'(CLKS_PER_BIT - 1);

      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (clr) begin
          r_cnt <= '0;
        end else if (en) begin
          r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end
      end

      assign bit_done = en && (r_cnt == c_last);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : seq_serializer
// Purpose  : Parallel-to-serial stage feeding the sequence detector's x
//            input. Accepts WIDTH-bit words on a valid/ready handshake, keeps
//            one extra word in a hold register so consecutive words stream
//            without gaps, and holds each bit for CLKS_PER_BIT cycles. The
//            line sits at IDLE_LEVEL when no word is in flight.
// Ports    : clk        - clock
//            rst        - asynchronous active-high reset
//            din        - parallel word, sampled only at the accept edge
//            din_valid  - din holds a word
//            din_ready  - a word can be taken (registered, no path from
//                         din_valid)
//            sout       - serial bit
//            sout_valid - sout carries a data bit
//            sof        - every cycle of a word's first bit
//            busy       - shifter or hold register occupied
// Revision : 1.0 - initial release
// ============================================================================
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] c_last_bit = BW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_n;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_hold_n;
  logic             r_hold_full;
  logic             w_hold_full_n;
  logic [BW-1:0]    r_bit_cnt;
  logic [BW-1:0]    w_bit_cnt_n;

  logic r_sout;
  logic r_sout_valid;
  logic r_sof;
  logic r_busy;
  logic r_ready;

  logic w_accept;
  logic w_bit_done;
  logic w_load;
  logic w_last;

  // Bit currently presented on the line for a given shifter content.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Shifter contents after the current bit has been sent.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) begin
      return {w[WIDTH-2:0], IDLE_LEVEL};
    end else begin
      return {IDLE_LEVEL, w[WIDTH-1:1]};
    end
  endfunction

  assign w_accept = din_valid && r_ready;
  assign w_last   = (r_state == SHIFT) && w_bit_done && (r_bit_cnt == c_last_bit);

  seq_bit_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_load),
    .en       (r_state == SHIFT),
    .bit_done (w_bit_done)
  );

  always_comb begin
    w_state_n     = r_state;
    w_shift_n     = r_shift;
    w_hold_n      = r_hold;
    w_hold_full_n = r_hold_full;
    w_bit_cnt_n   = r_bit_cnt;
    w_load        = 1'b0;

    case (r_state)
      IDLE: begin
        // An idle shifter takes the word directly; the hold stays empty.
        if (w_accept) begin
          w_shift_n   = din;
          w_bit_cnt_n = '0;
          w_state_n   = SHIFT;
          w_load      = 1'b1;
        end
      end

      SHIFT: begin
        if (w_last) begin
          if (r_hold_full) begin
            w_shift_n     = r_hold;
            w_hold_full_n = 1'b0;
            w_bit_cnt_n   = '0;
            w_load        = 1'b1;
          end else if (w_accept) begin
            // Word arriving on the last bit goes straight in: no gap.
            w_shift_n   = din;
            w_bit_cnt_n = '0;
            w_load      = 1'b1;
          end else begin
            w_shift_n   = '0;
            w_bit_cnt_n = '0;
            w_state_n   = IDLE;
          end
        end else if (w_bit_done) begin
          w_shift_n   = advance(r_shift);
          w_bit_cnt_n = r_bit_cnt + 1'b1;
        end

        // Mid-word accepts park in the hold register. On the last bit an
        // accept is only possible with the hold empty and was taken above.
        if (w_accept && !w_last) begin
          w_hold_n      = din;
          w_hold_full_n = 1'b1;
        end
      end

      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_bit_cnt    <= '0;
      r_sout       <= IDLE_LEVEL;
      r_sout_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_busy       <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_shift      <= w_shift_n;
      r_hold       <= w_hold_n;
      r_hold_full  <= w_hold_full_n;
      r_bit_cnt    <= w_bit_cnt_n;
      r_sout       <= (w_state_n == SHIFT) ? head_bit(w_shift_n) : IDLE_LEVEL;
      r_sout_valid <= (w_state_n == SHIFT);
      r_sof        <= (w_state_n == SHIFT) && (w_bit_cnt_n == '0);
      r_busy       <= (w_state_n == SHIFT) || w_hold_full_n;
      r_ready      <= !w_hold_full_n;
    end
  end

  assign din_ready  = r_ready;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign sof        = r_sof;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seq_serializer
// Purpose  : Self-checking bench for seq_serializer. Three instances cover
//            the default configuration, CLKS_PER_BIT=3 and LSB-first order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_serializer;

  typedef struct packed {
    logic b;
    logic s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din_a [3];
  logic [2:0] dv;
  wire  [2:0] dr;
  wire  [2:0] sv;
  wire  [2:0] so;
  wire  [2:0] sf;
  wire  [2:0] by;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1)) u_dut0 (
    .clk(clk), .rst(rst), .din(din_a[0]), .din_valid(dv[0]), .din_ready(dr[0]),
    .sout(so[0]), .sout_valid(sv[0]), .sof(sf[0]), .busy(by[0])
  );

  seq_serializer #(.WIDTH(8), .CLKS_PER_BIT(3), .MSB_FIRST(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din_a[1]), .din_valid(dv[1]), .din_ready(dr[1]),
    .sout(so[1]), .sout_valid(sv[1]), .sof(sf[1]), .busy(by[1])
  );

  seq_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(0)) u_dut2 (
    .clk(clk), .rst(rst), .din(din_a[2]), .din_valid(dv[2]), .din_ready(dr[2]),
    .sout(so[2]), .sout_valid(sv[2]), .sof(sf[2]), .busy(by[2])
  );

  task automatic check(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0b, required %0b", name, act, req);
    end
  endtask

  task automatic checkv(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Expected per-cycle line content for one accepted word.
  task automatic push_word(input int id, input logic [7:0] w);
    int   cpb;
    logic msb;
    logic b;
    exp_t e;
    cpb = (id == 1) ? 3 : 1;
    msb = (id != 2);
    for (int i = 0; i < 8; i++) begin
      b = msb ? w[7-i] : w[i];
      for (int c = 0; c < cpb; c++) begin
        e.b = b;
        e.s = (i == 0);
        case (id)
          0:       q0.push_back(e);
          1:       q1.push_back(e);
          default: q2.push_back(e);
        endcase
      end
    end
  endtask

  // Offer a word from a negedge; returns at the negedge after the accept.
  task automatic send(input int id, input logic [7:0] w);
    int n;
    n = 0;
    din_a[id] = w;
    dv[id]    = 1'b1;
    while (dr[id] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (dr[id] !== 1'b1) begin
      n_err++;
      $display("FAIL send%0d timeout: din_ready=%0b, required 1", id, dr[id]);
      dv[id] = 1'b0;
      return;
    end
    @(posedge clk);
    push_word(id, w);
    @(negedge clk);
    dv[id]    = 1'b0;
    din_a[id] = 8'h00;
  endtask

  task automatic mon_one(input int id, input logic v, input logic b, input logic s);
    exp_t e;
    logic have;
    if (v !== 1'b1) return;
    have = 1'b0;
    case (id)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    n_vec++;
    if (!have) begin
      n_err++;
      $display("FAIL mon%0d unexpected bit: got sout=%0b sof=%0b, required no valid bit",
               id, b, s);
    end else if (b !== e.b || s !== e.s) begin
      n_err++;
      $display("FAIL mon%0d bit: got sout=%0b sof=%0b, required sout=%0b sof=%0b",
               id, b, s, e.b, e.s);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((by !== 3'b000 || sv !== 3'b000) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkv("idle reached", (by === 3'b000) ? 1 : 0, 1);
    checkv("q0 drained", q0.size(), 0);
    checkv("q1 drained", q1.size(), 0);
    checkv("q2 drained", q2.size(), 0);
  endtask

  initial begin
    int run;
    dv = 3'b000;
    for (int i = 0; i < 3; i++) din_a[i] = 8'h00;

    fork
      forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
          mon_one(0, sv[0], so[0], sf[0]);
          mon_one(1, sv[1], so[1], sf[1]);
          mon_one(2, sv[2], so[2], sf[2]);
        end
      end
    join_none

    // Reset state
    #2;
    check("rst din_ready",  dr[0], 1'b0);
    check("rst sout",       so[0], 1'b0);
    check("rst sout_valid", sv[0], 1'b0);
    check("rst sof",        sf[0], 1'b0);
    check("rst busy",       by[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("ready before first edge", dr[0], 1'b0);
    @(negedge clk);
    check("ready after first edge", &dr, 1'b1);

    // Single word, MSB first
    send(0, 8'hB0);
    wait_idle();

    // Back-to-back words through the hold register
    send(0, 8'hA5);
    @(negedge clk);
    send(0, 8'h3C);
    for (int i = 0; i < 6; i++) begin
      check("b2b ready low", dr[0], 1'b0);
      check("b2b contiguous", sv[0], 1'b1);
      @(negedge clk);
    end
    check("b2b ready back", dr[0], 1'b1);
    check("b2b second sof", sf[0], 1'b1);
    wait_idle();

    // Three clocks per bit
    send(1, 8'h81);
    run = 0;
    while (sv[1] === 1'b1 && run < 40) begin
      run++;
      @(negedge clk);
    end
    checkv("cpb3 valid run", run, 24);
    wait_idle();

    // LSB first
    send(2, 8'h0D);
    wait_idle();

    // Backpressure: FF held valid while ready is low
    send(0, 8'h12);
    send(0, 8'h34);
    check("bp ready low", dr[0], 1'b0);
    check("bp busy", by[0], 1'b1);
    send(0, 8'hFF);
    wait_idle();

    // Reset in the middle of a word with the hold occupied
    send(0, 8'hF0);
    send(0, 8'h55);
    @(negedge clk);
    @(negedge clk);
    check("pre-rst sout bit4", so[0], 1'b1);
    #1 rst = 1'b1;
    #1;
    check("midrst sout",       so[0], 1'b0);
    check("midrst sout_valid", sv[0], 1'b0);
    check("midrst sof",        sf[0], 1'b0);
    check("midrst busy",       by[0], 1'b0);
    check("midrst din_ready",  dr[0], 1'b0);
    q0.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst ready", dr[0], 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("post-rst line idle", so[0] | sv[0] | by[0], 1'b0);
      @(negedge clk);
    end
    checkv("post-rst q0 empty", q0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
